// File: rtl/adder_tb_pkg.sv
// Shared constants for the adder checker: FSM encoding and default sizing.
package adder_tb_pkg;
  localparam int N_DEF         = 16;
  localparam int FILE_SIZE_DEF = 30000;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// 32-bit up counter with synchronous clear and enable; sticks at all-ones.
module sat_counter #(
  parameter logic [31:0] CLR_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  output logic [31:0] cnt
);
  always_ff @(posedge clk) begin
    if (clr)
      cnt <= CLR_VAL;
    else if (en && cnt != 32'hFFFF_FFFF)
      cnt <= cnt + 32'd1;
  end
endmodule

// File: rtl/adder_checker.sv
// Compares a DUV adder against a reference over a fixed-length run,
// counting mismatches, capturing the first one and auditing the reference.
module adder_checker
  import adder_tb_pkg::*;
#(
  parameter int n         = N_DEF,
  parameter int file_size = FILE_SIZE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [n-1:0] s_ref,
  input  logic [n-1:0] s_duv,
  input  logic         cout_ref,
  input  logic         cout_duv,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [31:0]  vec_cnt,
  output logic [31:0]  err_cnt,
  output logic         err_pulse,
  output logic         ref_err,
  output logic [31:0]  fe_idx,
  output logic [n-1:0] fe_a,
  output logic [n-1:0] fe_b,
  output logic [n-1:0] fe_s_duv,
  output logic         fe_cin,
  output logic         fe_cout_duv
);
  logic [1:0] state, state_nxt;
  logic       start_go, accept, mismatch, last_vec;
  logic [n:0] golden;

  // A new run may be launched from IDLE or DONE; start is ignored mid-run.
  assign start_go = start && (state != RUN);
  assign accept   = (state == RUN) && in_valid;
  assign mismatch = accept && ((s_duv != s_ref) || (cout_duv != cout_ref));
  assign last_vec = (vec_cnt == 32'(file_size - 1));
  assign golden   = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = RUN;
      RUN:        if (accept && last_vec) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  sat_counter u_vec_cnt (
    .clk (clk),
    .clr (rst || start_go),
    .en  (accept),
    .cnt (vec_cnt)
  );

  sat_counter u_err_cnt (
    .clk (clk),
    .clr (rst || start_go),
    .en  (mismatch),
    .cnt (err_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      err_pulse   <= 1'b0;
      ref_err     <= 1'b0;
      fe_idx      <= '0;
      fe_a        <= '0;
      fe_b        <= '0;
      fe_s_duv    <= '0;
      fe_cin      <= 1'b0;
      fe_cout_duv <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_pulse <= mismatch;
      if (start_go) begin
        ref_err     <= 1'b0;
        fe_idx      <= '0;
        fe_a        <= '0;
        fe_b        <= '0;
        fe_s_duv    <= '0;
        fe_cin      <= 1'b0;
        fe_cout_duv <= 1'b0;
      end else begin
        if (accept && (golden != {cout_ref, s_ref}))
          ref_err <= 1'b1;
        // err_cnt still holds the pre-increment count, so zero marks the first error.
        if (mismatch && err_cnt == 32'd0) begin
          fe_idx      <= vec_cnt;
          fe_a        <= a;
          fe_b        <= b;
          fe_s_duv    <= s_duv;
          fe_cin      <= cin;
          fe_cout_duv <= cout_duv;
        end
      end
    end
  end

  // Status outputs decode registered state only.
  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && (err_cnt == 32'd0) && !ref_err;
endmodule

// File: tb/tb_adder_checker.sv
// Directed bench for adder_checker (n=16, file_size=4) plus a saturation
// check on a preset sat_counter instance.
module tb_adder_checker;
  logic        clk = 1'b0;
  logic        rst, start, in_valid, cin, cout_ref, cout_duv;
  logic [15:0] a, b, s_ref, s_duv;
  logic        busy, done, pass, err_pulse, ref_err, fe_cin, fe_cout_duv;
  logic [31:0] vec_cnt, err_cnt, fe_idx;
  logic [15:0] fe_a, fe_b, fe_s_duv;
  logic        sc_clr, sc_en;
  logic [31:0] sc_cnt;
  int          total = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  adder_checker #(.n(16), .file_size(4)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .cin(cin),
    .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv), .cout_ref(cout_ref),
    .cout_duv(cout_duv), .busy(busy), .done(done), .pass(pass),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt), .err_pulse(err_pulse),
    .ref_err(ref_err), .fe_idx(fe_idx), .fe_a(fe_a), .fe_b(fe_b),
    .fe_s_duv(fe_s_duv), .fe_cin(fe_cin), .fe_cout_duv(fe_cout_duv)
  );

  sat_counter #(.CLR_VAL(32'hFFFF_FFFE)) u_sat (
    .clk(clk), .clr(sc_clr), .en(sc_en), .cnt(sc_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then stable for checking and inputs may change.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] ta, input logic [15:0] tb_,
                     input logic tc, input logic [15:0] tsr, input logic [15:0] tsd,
                     input logic tcr, input logic tcd);
    in_valid = v; a = ta; b = tb_; cin = tc;
    s_ref = tsr; s_duv = tsd; cout_ref = tcr; cout_duv = tcd;
  endtask

  task automatic good();
    put(1'b1, 16'h0001, 16'h0002, 1'b0, 16'h0003, 16'h0003, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sc_clr = 1'b1; sc_en = 1'b0;
    put(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    cyc(); cyc();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_vec", vec_cnt, 32'd0);
    chk("rst_err", err_cnt, 32'd0);
    chk("rst_referr", {31'd0, ref_err}, 32'd0);
    chk("rst_feidx", fe_idx, 32'd0);
    chk("rst_epulse", {31'd0, err_pulse}, 32'd0);
    rst = 1'b0;

    // Run 1: start coincident with in_valid in IDLE; four matching vectors.
    start = 1'b1; good(); cyc();
    chk("r1_busy", {31'd0, busy}, 32'd1);
    chk("r1_vec0", vec_cnt, 32'd0);
    start = 1'b0;
    repeat (3) cyc();
    chk("r1_vec3", vec_cnt, 32'd3);
    cyc();
    chk("r1_done", {31'd0, done}, 32'd1);
    chk("r1_pass", {31'd0, pass}, 32'd1);
    chk("r1_vec4", vec_cnt, 32'd4);
    chk("r1_err", err_cnt, 32'd0);
    chk("r1_busy0", {31'd0, busy}, 32'd0);
    cyc();
    chk("r1_vec_hold", vec_cnt, 32'd4);

    // Run 2: start from DONE; vector index 2 mismatches on the sum.
    start = 1'b1; put(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    chk("r2_vec_clr", vec_cnt, 32'd0);
    chk("r2_done0", {31'd0, done}, 32'd0);
    good(); cyc(); cyc();
    chk("r2_nopulse", {31'd0, err_pulse}, 32'd0);
    put(1'b1, 16'h1234, 16'h0001, 1'b0, 16'h1235, 16'h1234, 1'b0, 1'b0); cyc();
    chk("r2_pulse", {31'd0, err_pulse}, 32'd1);
    chk("r2_err1", err_cnt, 32'd1);
    chk("r2_feidx", fe_idx, 32'd2);
    chk("r2_fesduv", {16'd0, fe_s_duv}, 32'h1234);
    chk("r2_fea", {16'd0, fe_a}, 32'h1234);
    chk("r2_referr", {31'd0, ref_err}, 32'd0);
    good(); cyc();
    chk("r2_pulse_end", {31'd0, err_pulse}, 32'd0);
    chk("r2_done", {31'd0, done}, 32'd1);
    chk("r2_pass", {31'd0, pass}, 32'd0);
    chk("r2_err_final", err_cnt, 32'd1);

    // Run 3: carry-out edge cases and reference audit.
    start = 1'b1; put(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    chk("r3_feidx_clr", fe_idx, 32'd0);
    put(1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1'b1, 1'b1); cyc();
    chk("r3_err0", err_cnt, 32'd0);
    chk("r3_referr0", {31'd0, ref_err}, 32'd0);
    put(1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0); cyc();
    chk("r3_referr1", {31'd0, ref_err}, 32'd1);
    chk("r3_err_same", err_cnt, 32'd0);
    put(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1); cyc();
    chk("r3_err_cout", err_cnt, 32'd1);
    chk("r3_feidx", fe_idx, 32'd2);
    chk("r3_fecout", {31'd0, fe_cout_duv}, 32'd1);
    put(1'b1, 16'h0003, 16'h0000, 1'b1, 16'h0004, 16'h0005, 1'b0, 1'b0); cyc();
    chk("r3_err2", err_cnt, 32'd2);
    chk("r3_fea_kept", {16'd0, fe_a}, 32'h0000);
    chk("r3_feidx_kept", fe_idx, 32'd2);
    chk("r3_pass", {31'd0, pass}, 32'd0);

    // Run 4: gaps in in_valid and start issued mid-run.
    start = 1'b1; put(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    chk("r4_referr_clr", {31'd0, ref_err}, 32'd0);
    repeat (3) cyc();
    chk("r4_idle_vec", vec_cnt, 32'd0);
    chk("r4_idle_busy", {31'd0, busy}, 32'd1);
    good(); cyc();
    in_valid = 1'b0; cyc();
    chk("r4_gap_vec", vec_cnt, 32'd1);
    start = 1'b1; good(); cyc();
    start = 1'b0;
    chk("r4_start_ign", vec_cnt, 32'd2);
    cyc(); cyc();
    chk("r4_done", {31'd0, done}, 32'd1);
    chk("r4_pass", {31'd0, pass}, 32'd1);

    // Run 5: reset mid-run, then a clean run.
    start = 1'b1; put(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0); cyc();
    start = 1'b0;
    put(1'b1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 16'h0007, 1'b0, 1'b0); cyc();
    good(); cyc();
    chk("r5_err_pre", err_cnt, 32'd1);
    rst = 1'b1; start = 1'b1; cyc();
    rst = 1'b0; start = 1'b0;
    chk("r5_busy", {31'd0, busy}, 32'd0);
    chk("r5_done", {31'd0, done}, 32'd0);
    chk("r5_vec", vec_cnt, 32'd0);
    chk("r5_err", err_cnt, 32'd0);
    chk("r5_feidx", fe_idx, 32'd0);
    cyc();
    chk("r5_stay_idle", {31'd0, busy}, 32'd0);
    start = 1'b1; in_valid = 1'b0; cyc();
    start = 1'b0; good();
    repeat (4) cyc();
    chk("r5_done2", {31'd0, done}, 32'd1);
    chk("r5_pass2", {31'd0, pass}, 32'd1);
    chk("r5_vec4", vec_cnt, 32'd4);

    // Saturating counter preset near the top.
    sc_clr = 1'b1; cyc();
    sc_clr = 1'b0;
    chk("sat_preset", sc_cnt, 32'hFFFF_FFFE);
    sc_en = 1'b1; cyc();
    chk("sat_max", sc_cnt, 32'hFFFF_FFFF);
    cyc(); cyc();
    chk("sat_hold", sc_cnt, 32'hFFFF_FFFF);
    sc_en = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/adder_checker.md
ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter n, default 16, operand/sum width of the adder under test.
REQ-002 Parameter file_size, default 30000, number of vectors per run.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse, begins a run.
REQ-006 in_valid  input  1  vector on cin/a/b/s_ref/s_duv/cout_ref/cout_duv is valid this cycle.
REQ-007 cin  input  1; a, b  input  n  stimulus applied to both adders.
REQ-008 s_ref, s_duv  input  n; cout_ref, cout_duv  input  1  reference and DUV results.
REQ-009 busy  output  1  run in progress; done  output  1  run complete; pass  output  1  done with zero errors.
REQ-010 vec_cnt, err_cnt  output  32  vectors accepted / mismatches in current run.
REQ-011 err_pulse  output  1  one-cycle pulse per mismatching vector.
REQ-012 ref_err  output  1  sticky: s_ref/cout_ref disagrees with internal a+b+cin.
REQ-013 fe_idx  output  32; fe_a, fe_b, fe_s_duv  output  n; fe_cin, fe_cout_duv  output  1  first-error capture.

Function
REQ-014 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-015 IDLE: start -> RUN, clearing vec_cnt, err_cnt, ref_err, fe_* to 0; in_valid ignored, including when coincident with start.
REQ-016 RUN: each cycle with in_valid accepts one vector; vec_cnt increments by 1 next cycle.
REQ-017 Mismatch = (s_duv != s_ref) or (cout_duv != cout_ref); err_cnt increments and err_pulse asserts exactly one cycle after the accepting edge.
REQ-018 On first mismatch of a run (err_cnt == 0), fe_idx = vec_cnt value before increment, fe_* = that vector; later mismatches never overwrite fe_*.
REQ-019 err_cnt saturates at 32'hFFFFFFFF; no wrap.
REQ-020 Internal golden sum is n+1 bits {cout,s} = a + b + cin; disagreement with {cout_ref,s_ref} sets ref_err, independent of mismatch counting.
REQ-021 RUN -> DONE on the edge accepting vector number file_size (vec_cnt becomes file_size); further in_valid ignored.
REQ-022 start during RUN ignored; start in DONE behaves as in IDLE (new run, counters cleared).
REQ-023 busy = (state == RUN); done = (state == DONE); pass = done and err_cnt == 0 and not ref_err; all registered outputs.
REQ-024 in_valid low in RUN: no counter change, err_pulse low, state held indefinitely.

Reset
REQ-025 rst high at a rising edge: state IDLE; busy, done, pass, err_pulse, ref_err 0; vec_cnt, err_cnt, fe_* 0.
REQ-026 rst mid-run aborts the run with no done indication; rst has priority over start and in_valid in the same cycle.

Structure
REQ-027 Shared package adder_tb_pkg holds FSM state encoding, default n (16) and default file_size (30000).
REQ-028 One sub-module sat_counter (32-bit, synchronous clear, enable, saturating) instantiated for vec_cnt and err_cnt.

Verification
REQ-029 n=16, file_size=4; start, 4 matching vectors (a=16'h0001,b=16'h0002,cin=0,s=16'h0003) -> done=1, pass=1, vec_cnt=4, err_cnt=0.
REQ-030 Vector 2 of 4 with s_duv=16'h1234, s_ref=16'h1235 -> err_pulse one cycle later, err_cnt=1, fe_idx=2, fe_s_duv=16'h1234, pass=0.
REQ-031 a=16'hFFFF, b=16'h0001, cin=1, s_ref=16'h0001, cout_ref=1, DUV equal -> no mismatch, ref_err=0; same with cout_ref=0, cout_duv=0 -> ref_err=1, err_cnt unchanged.
REQ-032 in_valid pulses with gaps and start coincident with in_valid in IDLE -> only in-RUN valid cycles counted; start during RUN ignored.
REQ-033 rst asserted after 2 of 4 vectors -> next cycle IDLE, all counters 0, done=0; fresh start then completes normally.
REQ-034 Force err_cnt near saturation (file_size large, all mismatching, counter preset via 32'hFFFFFFFE start in a sat_counter unit test) -> holds 32'hFFFFFFFF.
